tff_toggle_monitor: RTL and testbench
=====================================

TFF_TOGGLE_MONITOR -- requirements
Module: tff_toggle_monitor

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of toggle_cnt and run_len (legal range 4..16).
REQ-002 Parameter STUCK_LIM, default 16, is the run length that declares din stuck (legal range 2..2^CNT_W-1).
REQ-003 clk  input  1  single clock; every flop samples on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  sample enable; when low, the block holds all state.
REQ-006 clr  input  1  synchronous clear of counters and flags.
REQ-007 din  input  1  toggle flip-flop output being monitored (the DUT's out, sampled at clk).
REQ-008 rise_p  output  1  one-cycle pulse for a detected 0->1 transition.
REQ-009 fall_p  output  1  one-cycle pulse for a detected 1->0 transition.
REQ-010 toggle_cnt  output  CNT_W  saturating count of detected transitions.
REQ-011 run_len  output  CNT_W  cycles (enabled samples) since the last transition, saturating.
REQ-012 stuck  output  1  high while din has held one level for at least STUCK_LIM samples.
REQ-013 ovf  output  1  sticky flag: toggle_cnt saturated.

Function
REQ-014 All outputs are registered, with no combinational input-to-output path.
REQ-015 A sample is a rising clk with en=1; the result of sample N is visible after that same edge.
REQ-016 FSM states: INIT, TRK_LO, TRK_HI, STUCK; the internal register d_q holds the last sampled din.
REQ-017 INIT, first sample: d_q<=din; go to TRK_HI if din=1, else TRK_LO; run_len<=1; no edge pulse; toggle_cnt unchanged.
REQ-018 TRK_x with din==d_q: run_len<=run_len+1, saturating at 2^CNT_W-1; rise_p=fall_p=0.
REQ-019 TRK_x with din==d_q and the new run_len==STUCK_LIM: go to STUCK; stuck<=1 in the same edge.
REQ-020 TRK_x or STUCK with din!=d_q: rise_p<=din, fall_p<=~din; toggle_cnt+1; run_len<=1; d_q<=din; stuck<=0.
REQ-021 On the transition in REQ-020, the next state is TRK_HI if din=1, else TRK_LO.
REQ-022 STUCK with din==d_q: stay in STUCK; run_len keeps incrementing, saturating; stuck stays 1.
REQ-023 toggle_cnt at 2^CNT_W-1 plus a further edge: the count holds at max, ovf<=1, and the edge pulse still fires.
REQ-024 ovf clears only on rst or clr.
REQ-025 rise_p and fall_p are never high together.
REQ-026 Each pulse lasts exactly one clk, and both are 0 on any cycle with en=0.
REQ-027 en=0: state, d_q, counters and stuck hold; no transition is detected across the disabled gap until the next sample.
REQ-028 clr=1 at a rising clk, regardless of en: state<=INIT; toggle_cnt, run_len, stuck, ovf, rise_p and fall_p all <=0.
REQ-029 clr has priority over en and over any coincident edge; an edge in the clr cycle is not counted.
REQ-030 din is synchronous to clk (driven from the DUT clocking block); no synchronizer is instantiated.

Reset
REQ-031 rst=1 forces, immediately and independent of clk: state=INIT, d_q=0, toggle_cnt=0, run_len=0, stuck=0, ovf=0, rise_p=0, fall_p=0.
REQ-032 Assertion of rst mid-operation (any state, including STUCK) discards all history.
REQ-033 After rst deasserts, the first enabled sample is handled as INIT (REQ-017), so no spurious edge is reported.
REQ-034 rst deassertion is synchronous to clk by construction of the environment; the block needs no internal reset synchronizer.

Verification
REQ-035 Reset then en=1, din=1 constant: after edge 1, run_len=1 and rise_p=0; at run_len=16, stuck=1 and the state is STUCK.
REQ-036 din alternating 0,1,0,1 for 10 samples: toggle_cnt=9; rise_p/fall_p alternate every cycle; run_len=1 throughout; stuck never 1.
REQ-037 CNT_W=4 and 20 toggles: toggle_cnt stops at 15, ovf=1 from the 16th edge; a later clr returns toggle_cnt=0 and ovf=0.
REQ-038 din=0 for 5 samples, en=0 for 3 cycles with din changed to 1, then en=1: exactly one rise_p, one cycle after en returns; run_len holds at 5 during the gap.
REQ-039 While in STUCK (din=0 for 20 samples), din->1: fall_p=0, rise_p=1, stuck=0, toggle_cnt+1, run_len=1 on that edge.
REQ-040 rst asserted between clock edges during STUCK: all outputs are 0 before the next clk; the first sample after release produces no pulse.

Source files
------------

// File: rtl/tff_toggle_monitor.sv
// Toggle flip-flop activity monitor.
// Counts edges, tracks run length and flags a stuck input.
module tff_toggle_monitor #(
   parameter int CNT_W     = 8,
   parameter int STUCK_LIM = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             din,
   output logic             rise_p,
   output logic             fall_p,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic [CNT_W-1:0] run_len,
   output logic             stuck,
   output logic             ovf
);

   localparam logic [1:0] INIT   = 2'd0;
   localparam logic [1:0] TRK_LO = 2'd1;
   localparam logic [1:0] TRK_HI = 2'd2;
   localparam logic [1:0] STUCK  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LIM     = CNT_W'(STUCK_LIM);

   logic [1:0]       state;
   logic [1:0]       state_n;
   logic             d_q;
   logic             d_n;
   logic [CNT_W-1:0] cnt_n;
   logic [CNT_W-1:0] run_n;
   logic             stuck_n;
   logic             ovf_n;
   logic             rise_n;
   logic             fall_n;

   logic             edge_det;
   logic             cnt_sat;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] run_inc;
   logic [1:0]       trk_next;

   // Shared helpers: edge test, saturating increments, tracking target.
   always_comb begin
      edge_det = (din != d_q);
      cnt_sat  = (toggle_cnt == CNT_MAX);
      cnt_inc  = cnt_sat ? toggle_cnt : toggle_cnt + CNT_ONE;
      run_inc  = (run_len == CNT_MAX) ? run_len : run_len + CNT_ONE;
      trk_next = din ? TRK_HI : TRK_LO;
   end

   // Next-state and next-output decode; clr wins over en and edges.
   always_comb begin
      state_n = state;
      d_n     = d_q;
      cnt_n   = toggle_cnt;
      run_n   = run_len;
      stuck_n = stuck;
      ovf_n   = ovf;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      if (clr) begin
         state_n = INIT;
         cnt_n   = '0;
         run_n   = '0;
         stuck_n = 1'b0;
         ovf_n   = 1'b0;
      end else if (en) begin
         unique case (state)
            INIT: begin
               d_n     = din;
               state_n = trk_next;
               run_n   = CNT_ONE;
               stuck_n = 1'b0;
            end
            TRK_LO, TRK_HI, STUCK: begin
               if (edge_det) begin
                  d_n     = din;
                  state_n = trk_next;
                  rise_n  = din;
                  fall_n  = ~din;
                  cnt_n   = cnt_inc;
                  run_n   = CNT_ONE;
                  stuck_n = 1'b0;
                  if (cnt_sat) ovf_n = 1'b1;
               end else begin
                  run_n = run_inc;
                  if (state != STUCK && run_inc == LIM) begin
                     state_n = STUCK;
                     stuck_n = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // State and output registers; rst discards all history at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= INIT;
         d_q        <= 1'b0;
         toggle_cnt <= '0;
         run_len    <= '0;
         stuck      <= 1'b0;
         ovf        <= 1'b0;
         rise_p     <= 1'b0;
         fall_p     <= 1'b0;
      end else begin
         state      <= state_n;
         d_q        <= d_n;
         toggle_cnt <= cnt_n;
         run_len    <= run_n;
         stuck      <= stuck_n;
         ovf        <= ovf_n;
         rise_p     <= rise_n;
         fall_p     <= fall_n;
      end
   end

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// Directed bench for tff_toggle_monitor.
// Two instances: default widths and a narrow CNT_W=4 one.
module tb_tff_toggle_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0, clr = 1'b0, din = 1'b0;
   logic en4 = 1'b0, clr4 = 1'b0, din4 = 1'b0;

   logic       rise_p, fall_p, stuck, ovf;
   logic [7:0] toggle_cnt, run_len;
   logic       rise4, fall4, stuck4, ovf4;
   logic [3:0] cnt4, run4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tff_toggle_monitor #(.CNT_W(8), .STUCK_LIM(16)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
      .rise_p(rise_p), .fall_p(fall_p),
      .toggle_cnt(toggle_cnt), .run_len(run_len),
      .stuck(stuck), .ovf(ovf)
   );

   tff_toggle_monitor #(.CNT_W(4), .STUCK_LIM(8)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .clr(clr4), .din(din4),
      .rise_p(rise4), .fall_p(fall4),
      .toggle_cnt(cnt4), .run_len(run4),
      .stuck(stuck4), .ovf(ovf4)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all0(input string tag);
      chk({tag, " cnt"}, toggle_cnt, 0);
      chk({tag, " run"}, run_len, 0);
      chk({tag, " stuck"}, stuck, 0);
      chk({tag, " ovf"}, ovf, 0);
      chk({tag, " rise"}, rise_p, 0);
      chk({tag, " fall"}, fall_p, 0);
   endtask

   initial begin
      // reset state
      repeat (2) step();
      chk_all0("reset");
      chk("reset cnt4", cnt4, 0);
      rst = 1'b0;

      // constant 1: INIT then run to STUCK
      en = 1'b1; din = 1'b1;
      step();
      chk("init run", run_len, 1);
      chk("init rise", rise_p, 0);
      chk("init cnt", toggle_cnt, 0);
      for (int k = 2; k <= 20; k++) begin
         step();
         chk("c1 run", run_len, k);
         chk("c1 stuck", stuck, (k >= 16) ? 1 : 0);
         chk("c1 rise", rise_p, 0);
      end
      din = 1'b0;
      step();
      chk("c1 fall", fall_p, 1);
      chk("c1 rise0", rise_p, 0);
      chk("c1 unstuck", stuck, 0);
      chk("c1 cnt", toggle_cnt, 1);
      chk("c1 run1", run_len, 1);

      clr = 1'b1;
      step();
      chk_all0("clr1");
      clr = 1'b0;

      // alternating din for 10 samples
      for (int i = 0; i < 10; i++) begin
         din = i[0];
         step();
         chk("alt rise", rise_p, (i > 0) ? i % 2 : 0);
         chk("alt fall", fall_p, (i > 0) ? 1 - i % 2 : 0);
         chk("alt run", run_len, 1);
         chk("alt stuck", stuck, 0);
      end
      chk("alt cnt", toggle_cnt, 9);

      // enable gap hides the edge until the next sample
      clr = 1'b1;
      step();
      clr = 1'b0;
      din = 1'b0;
      repeat (5) step();
      chk("gap pre run", run_len, 5);
      en = 1'b0; din = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("gap run", run_len, 5);
         chk("gap rise", rise_p, 0);
         chk("gap fall", fall_p, 0);
      end
      en = 1'b1;
      step();
      chk("gap edge rise", rise_p, 1);
      chk("gap edge run", run_len, 1);
      chk("gap edge cnt", toggle_cnt, 1);
      step();
      chk("gap after rise", rise_p, 0);

      // leave STUCK low with a rising edge
      clr = 1'b1;
      step();
      clr = 1'b0;
      din = 1'b0;
      repeat (20) step();
      chk("st0 run", run_len, 20);
      chk("st0 stuck", stuck, 1);
      din = 1'b1;
      step();
      chk("st0 rise", rise_p, 1);
      chk("st0 fall", fall_p, 0);
      chk("st0 stuck", stuck, 0);
      chk("st0 cnt", toggle_cnt, 1);
      chk("st0 run1", run_len, 1);

      // clr beats a coincident edge
      clr = 1'b1; din = 1'b0;
      step();
      chk_all0("clr edge");
      clr = 1'b0;

      // async reset between edges while STUCK
      repeat (16) step();
      chk("pre rst stuck", stuck, 1);
      rst = 1'b1;
      #2;
      chk_all0("async rst");
      #1;
      rst = 1'b0;
      din = 1'b1;
      step();
      chk("post rst rise", rise_p, 0);
      chk("post rst fall", fall_p, 0);
      chk("post rst cnt", toggle_cnt, 0);
      chk("post rst run", run_len, 1);

      // narrow counter: saturation and sticky ovf
      en4 = 1'b1; din4 = 1'b0;
      step();
      chk("n init cnt", cnt4, 0);
      for (int i = 1; i <= 20; i++) begin
         din4 = i[0];
         step();
         chk("n cnt", cnt4, (i < 15) ? i : 15);
         chk("n ovf", ovf4, (i >= 16) ? 1 : 0);
         chk("n rise", rise4, i % 2);
         chk("n fall", fall4, 1 - i % 2);
      end
      for (int j = 1; j <= 20; j++) begin
         step();
         chk("n run", run4, (j + 1 < 15) ? j + 1 : 15);
         chk("n stuck", stuck4, (j + 1 >= 8) ? 1 : 0);
      end
      chk("n ovf hold", ovf4, 1);
      clr4 = 1'b1;
      step();
      chk("n clr cnt", cnt4, 0);
      chk("n clr ovf", ovf4, 0);
      chk("n clr run", run4, 0);
      chk("n clr stuck", stuck4, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
